// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Byte-stream program loader. Parses LEN, {HI,LO} pairs and a
//                trailing checksum byte, writes 15-bit instruction words into
//                the instruction memory from address 0 and holds the CPU until
//                the image is complete and its checksum verifies.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_w,
    output logic [7:0]  im_addr,
    output logic [14:0] im_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_count;
    logic [7:0]  r_addr;
    logic [7:0]  r_sum;
    logic [6:0]  r_opcode;

    logic        w_accept;
    logic [7:0]  w_sum;
    state_t      w_state_nxt;

    // A byte moves the FSM only when both sides agree on the handshake
    assign w_accept = in_valid && in_ready;
    assign w_sum    = r_sum + in_data;

    // Next-state decode; registered outputs are derived from it so they
    // switch on the same edge as the state itself
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                S_LEN:   w_state_nxt = (in_data == 8'd0) ? S_CHK : S_HI;
                S_HI:    w_state_nxt = in_data[7] ? S_ERR : S_LO;
                S_LO:    w_state_nxt = (r_count == 8'd1) ? S_CHK : S_HI;
                S_CHK:   w_state_nxt = (w_sum == 8'd0) ? S_DONE : S_ERR;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Loader state, datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_LEN;
            r_count  <= 8'd0;
            r_addr   <= 8'd0;
            r_sum    <= 8'd0;
            r_opcode <= 7'd0;
            in_ready <= 1'b1;
            im_w     <= 1'b0;
            im_addr  <= 8'd0;
            im_data  <= 15'd0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; HI always separates two LO bytes
            im_w    <= 1'b0;
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_sum <= w_sum;
                case (r_state)
                    S_LEN: begin
                        r_count <= in_data;
                        r_addr  <= 8'd0;
                    end
                    S_HI: begin
                        r_opcode <= in_data[6:0];
                    end
                    S_LO: begin
                        im_w    <= 1'b1;
                        im_addr <= r_addr;
                        im_data <= {r_opcode, in_data};
                        // At N=255 this reaches 255 after the last word, which is never written
                        r_addr  <= r_addr + 8'd1;
                        r_count <= r_count - 8'd1;
                    end
                    default: ;
                endcase
            end
            in_ready <= (w_state_nxt != S_DONE) && (w_state_nxt != S_ERR);
            cpu_hold <= (w_state_nxt != S_DONE);
            done     <= (w_state_nxt == S_DONE);
            error    <= (w_state_nxt == S_ERR);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Self-checking bench for program_loader. Stimulus pushes the
//                expected memory writes into a queue; a monitor pops and
//                compares on every im_w pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_w;
    logic [7:0]  im_addr;
    logic [14:0] im_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_cmp;
    int n_bad;

    logic [22:0] exp_q[$];

    program_loader dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_w     (im_w),
        .im_addr  (im_addr),
        .im_data  (im_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && im_w) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", im_addr, im_data);
            end else begin
                logic [22:0] e;
                e = exp_q.pop_front();
                if ({im_addr, im_data} !== e) begin
                    n_bad++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             im_addr, im_data, e[22:15], e[14:0]);
                end
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Present one byte for one edge; optionally follow with an idle cycle
    task automatic send(input logic [7:0] b, input bit gap);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 8'hA5;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [14:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic chk_status(input string name, input bit rdy, input bit hold,
                              input bit dn, input bit er);
        chk({name, "_ready"}, {31'd0, in_ready}, {31'd0, rdy});
        chk({name, "_hold"},  {31'd0, cpu_hold}, {31'd0, hold});
        chk({name, "_done"},  {31'd0, done},     {31'd0, dn});
        chk({name, "_error"}, {31'd0, error},    {31'd0, er});
    endtask

    task automatic chk_drained(input string name);
        @(negedge clk);
        chk({name, "_pending_writes"}, exp_q.size(), 32'd0);
    endtask

    // Two-word image. Bytes 02+10+05+20+FF = 0x136, so CHK = 0xCA closes the sum to 0.
    task automatic two_word(input bit gap);
        exp_wr(8'd0, 15'h1005);
        exp_wr(8'd1, 15'h20FF);
        send(8'h02, gap);
        send(8'h10, gap);
        send(8'h05, gap);
        chk("gap_ready_mid", {31'd0, in_ready}, 32'd1);
        send(8'h20, gap);
        send(8'hFF, gap);
        chk_status("pre_chk", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'hCA, gap);
        chk_status("two_word", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_drained("two_word");
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;

        // Reset state
        do_reset();
        @(negedge clk);
        chk_status("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset_im_w", {31'd0, im_w}, 32'd0);
        chk("reset_im_addr", {24'd0, im_addr}, 32'd0);

        // Back-to-back two-word load
        @(posedge clk); #1;
        two_word(1'b0);

        // Same stream through a source idling every other cycle
        do_reset();
        two_word(1'b1);

        // Opcode byte with bit 7 set
        do_reset();
        send(8'h01, 1'b0);
        send(8'h80, 1'b0);
        chk_status("bad_hi", 1'b0, 1'b1, 1'b0, 1'b1);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        chk_status("bad_hi_ignored", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_drained("bad_hi");

        // Checksum mismatch after one valid word
        do_reset();
        exp_wr(8'd0, 15'h0007);
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h07, 1'b0);
        send(8'h00, 1'b0);
        chk_status("bad_chk", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_drained("bad_chk");

        // Empty image: LEN=0, CHK=0
        do_reset();
        send(8'h00, 1'b0);
        chk_status("empty_mid", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h00, 1'b0);
        chk_status("empty", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_drained("empty");

        // Reset during the write pulse of word 3 of a 10-word load
        do_reset();
        send(8'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) exp_wr(i[7:0], {i[6:0], 8'(i * 3)});
            send({1'b0, i[6:0]}, 1'b0);
            send(8'(i * 3), 1'b0);
        end
        chk("mid_im_w_before", {31'd0, im_w}, 32'd1);
        chk("mid_im_addr", {24'd0, im_addr}, 32'd2);
        reset = 1'b1;
        #1;
        chk("mid_im_w_async", {31'd0, im_w}, 32'd0);
        chk_status("mid_reset", 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_pending", exp_q.size(), 32'd0);
        // Fresh load: 01+3F+AA = 0xEA, CHK = 0x16
        exp_wr(8'd0, 15'h3FAA);
        send(8'h01, 1'b0);
        send(8'h3F, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h16, 1'b0);
        chk_status("reload", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_drained("reload");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
